fifo_port_arbiter: RTL

Sequencer and two-port arbiter in front of the 32x8 FIFO subsystem. Accepts single-cycle push and pop requests from independent write and read requesters, and serialises them onto the FIFO's start/write/data_in/done handshake. Gates each request against full/empty, returns data and ack/nack pulses, and schedules FIFO clears. Sits between the system requesters and the FIFO top level; it is the only driver of the FIFO control inputs.

---
 rtl/fifo_port_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fifo_port_arbiter.sv
// Two-port push/pop arbiter and sequencer driving the FIFO start/write/done handshake.
// Define FIFO_ARB_TIMEOUT_EN to enable the WAIT watchdog and the sticky timeout_err flag.
module fifo_port_arbiter #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_pend,
  output logic             wr_ack,
  output logic             wr_nack,
  input  logic             rd_req,
  output logic             rd_pend,
  output logic             rd_ack,
  output logic             rd_nack,
  output logic [WIDTH-1:0] rd_data,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic             fifo_start,
  output logic             fifo_write,
  output logic             fifo_clear,
  output logic [WIDTH-1:0] fifo_data_in,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_done,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StClear} state_e;

  state_e           state_q, state_d;
  logic             wr_pend_q, rd_pend_q, clr_pend_q;
  logic [WIDTH-1:0] wr_data_q, rd_data_q;
  logic             grant_wr_q, grant_wr_d;
  logic             nack_q, nack_d;
  logic             last_wr_q;  // 1: last grant went to the write port
  logic             timeout_hit;

  always_comb begin
    state_d    = state_q;
    grant_wr_d = grant_wr_q;
    nack_d     = nack_q;
    unique case (state_q)
      StIdle: begin
        if (clr_pend_q) begin
          state_d = StClear;
        end else if (wr_pend_q || rd_pend_q) begin
          // Round robin on a tie: favour the port that did not win last time.
          grant_wr_d = wr_pend_q && (!rd_pend_q || !last_wr_q);
          nack_d     = grant_wr_d ? fifo_full : fifo_empty;
          state_d    = nack_d ? StResp : StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (fifo_done) begin
          state_d = StResp;
        end else if (timeout_hit) begin
          nack_d  = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_wr_q <= 1'b0;
      nack_q     <= 1'b0;
      last_wr_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_wr_q <= grant_wr_d;
      nack_q     <= nack_d;
      if (state_q == StResp) begin
        last_wr_q <= grant_wr_q;
      end
      // A request landing on a set flag (including the RESP cycle) is dropped.
      if (wr_req && !wr_pend_q) begin
        wr_pend_q <= 1'b1;
        wr_data_q <= wr_data;
      end else if (state_q == StResp && grant_wr_q) begin
        wr_pend_q <= 1'b0;
      end
      if (rd_req && !rd_pend_q) begin
        rd_pend_q <= 1'b1;
      end else if (state_q == StResp && !grant_wr_q) begin
        rd_pend_q <= 1'b0;
      end
      if (clr_req && !clr_pend_q) begin
        clr_pend_q <= 1'b1;
      end else if (state_q == StClear) begin
        clr_pend_q <= 1'b0;
      end
      if (state_q == StWait && fifo_done && !grant_wr_q) begin
        rd_data_q <= fifo_data_out;
      end
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntWidth-1:0] wait_cnt_q;
  logic                timeout_err_q;

  assign timeout_hit = (state_q == StWait) && !fifo_done &&
                       (wait_cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + 1'b1 : '0;
      if (state_q == StClear) begin
        timeout_err_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Moore outputs decoded from registered state only.
  assign busy         = (state_q != StIdle);
  assign fifo_start   = (state_q == StIssue);
  assign fifo_write   = (state_q == StIssue) && grant_wr_q;
  assign fifo_data_in = ((state_q == StIssue || state_q == StWait) && grant_wr_q) ?
                        wr_data_q : '0;
  assign fifo_clear   = (state_q == StClear);
  assign clr_ack      = (state_q == StClear);
  assign wr_ack       = (state_q == StResp) && grant_wr_q && !nack_q;
  assign wr_nack      = (state_q == StResp) && grant_wr_q && nack_q;
  assign rd_ack       = (state_q == StResp) && !grant_wr_q && !nack_q;
  assign rd_nack      = (state_q == StResp) && !grant_wr_q && nack_q;
  assign wr_pend      = wr_pend_q;
  assign rd_pend      = rd_pend_q;
  assign rd_data      = rd_data_q;

endmodule
